cii_table_ram: RTL and testbench
================================

CII_TABLE_RAM -- requirements
Module: cii_table_ram

Interface
REQ-001 SHALL have parameter COLS, default 70, meaning characters per row.
REQ-002 SHALL have parameter ROWS, default 30, meaning character rows.
REQ-003 SHALL have parameter DW, default 8, meaning character code width (ASCII).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 char_x_rd  input  7  read column.
REQ-007 char_y_rd  input  5  read row.
REQ-008 char_x_we  input  7  write column.
REQ-009 char_y_we  input  5  write row.
REQ-010 rd  input  1  read enable.
REQ-011 we_vld  input  1  write request valid.
REQ-012 we_rdy  output  1  ready to accept a write.
REQ-013 ascii_we  input  8  character code to write.
REQ-014 ascii_rd  output  8  character code read.

Function
REQ-015 SHALL store COLS*ROWS (2100) entries of DW bits each, one per screen character cell.
REQ-016 Linear address SHALL be y*COLS+x, computed in 12 bits without truncation.
REQ-017 Write SHALL occur at a clock edge when we_vld=1 and we_rdy=1; ascii_we is stored at (char_x_we, char_y_we).
REQ-018 A write SHALL be silently dropped when we_vld=1 and we_rdy=0.
REQ-019 A write with char_x_we>=COLS or char_y_we>=ROWS SHALL be dropped with no side effect; x=70 specifically is out of range.
REQ-020 Read SHALL be registered with 1-cycle latency: when rd=1 at edge N, ascii_rd SHALL show mem[addr(char_x_rd, char_y_rd)] after edge N.
REQ-021 When rd=0, ascii_rd SHALL hold its previous value.
REQ-022 A read with char_x_rd>=COLS or char_y_rd>=ROWS SHALL return 8'h00.
REQ-023 A same-cycle read and write to the same cell SHALL return the old (pre-write) data (read-first behaviour).
REQ-024 Read and write ports SHALL operate independently in the same cycle.
REQ-025 After reset, a clear sequencer SHALL write 8'h00 to addresses 0..2099, one per cycle, in ascending order.
REQ-026 we_rdy SHALL be 0 while clearing and SHALL go to 1 on the edge after address 2099 is cleared; it SHALL remain 1 until the next reset.
REQ-027 Reads during clearing SHALL be permitted and SHALL return either cleared (00) or not-yet-cleared contents per address.

Reset
REQ-028 On an rstn=0 edge: ascii_rd SHALL be 8'h00, we_rdy 0, and the clear pointer 0.
REQ-029 Clearing SHALL start on the first edge with rstn=1.
REQ-030 Reset asserted mid-clear or mid-operation SHALL restart the full clear from address 0.
REQ-031 Memory array contents SHALL be unaffected by reset itself, except through the clear sequence.

Structure
REQ-032 COLS, ROWS, DW, DEPTH (=COLS*ROWS) and the address width (12) SHALL live in the shared package cii_pkg.
REQ-033 Storage SHALL be a single sub-module cii_dpram: a simple dual-port RAM with one synchronous write port, one registered read port and read-first behaviour, inferable as block RAM.
REQ-034 The top level SHALL contain the address computation, range checks, clear sequencer, and the write-port mux selecting between clear and user writes.

Verification
REQ-035 Reset then count cycles -> we_rdy=0 for exactly 2100 cycles after rstn rises, then 1; every cell reads 8'h00.
REQ-036 Write 8'h41 at (0,0), 8'h5A at (69,29); read both with rd=1 -> 8'h41 and 8'h5A appear one cycle after each read request.
REQ-037 Write 8'h33 at (70,0) and at (5,30) -> no cell changes; a read at (70,0) returns 8'h00.
REQ-038 Write 8'h61 to (10,3) while simultaneously reading (10,3) -> that read returns 8'h00; the next read returns 8'h61.
REQ-039 Hold rd=0 after reading 8'h41 and change the read address -> ascii_rd stays 8'h41.
REQ-040 Pulse rstn low at clear pointer 1000, and issue we_vld during clearing -> clearing restarts, we_rdy rises 2100 cycles after the reset release, and the dropped write leaves its cell at 8'h00.

Source files
------------

// File: rtl/cii_pkg.sv
// Shared constants and types for the character-cell table RAM.
//   COLS/ROWS : screen geometry in character cells
//   DW        : character code width
//   DEPTH     : number of cells (COLS*ROWS)
//   AW        : linear cell address width (wide enough for any x/y pair)
//   XW/YW     : column / row coordinate widths
package cii_pkg;

    localparam int COLS  = 70;
    localparam int ROWS  = 30;
    localparam int DW    = 8;
    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = 12;
    localparam int XW    = 7;
    localparam int YW    = 5;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clr_state_t;

    // Linear cell address y*cols+x. Evaluated at full AW width so that
    // out-of-range coordinates never alias onto a valid cell by truncation.
    function automatic logic [AW-1:0] cell_addr(input logic [XW-1:0] x,
                                                input logic [YW-1:0] y,
                                                input int            cols);
        return AW'(y) * AW'(cols) + AW'(x);
    endfunction

endpackage

// File: rtl/cii_dpram.sv
// Simple dual-port RAM: one synchronous write port and one registered,
// read-first read port. Written so it maps onto a block RAM with an
// output register that has a synchronous clear.
// Ports:
//   clk      : clock
//   we       : write enable
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read enable; rd_data holds when low
//   rd_clr   : synchronous clear of rd_data (wins over rd_en)
//   rd_addr  : read address
//   rd_data  : registered read data
module cii_dpram #(
    parameter int DW    = 8,
    parameter int DEPTH = 2100,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic          rd_clr,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read of the array gives pre-write data on a same-cell
    // collision.
    always_ff @(posedge clk) begin
        if (rd_clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cii_table_ram.sv
// Character-cell table for a text display. Holds one character code per
// screen cell, addressed by (column, row). After every reset a clear
// sequencer zeroes the whole table, one cell per cycle, before user
// writes are accepted.
// Ports:
//   clk, rstn              : clock, synchronous active-low reset
//   char_x_rd, char_y_rd   : read cell coordinates
//   rd                     : read enable (ascii_rd holds when low)
//   ascii_rd               : registered read data (00 for out-of-range cells)
//   char_x_we, char_y_we   : write cell coordinates
//   we_vld, we_rdy         : write handshake; we_rdy low while clearing
//   ascii_we               : write data
//
// Clear sequencer states:
//   state    | meaning
//   ST_CLEAR | zeroing cell clr_ptr this cycle, user writes refused
//   ST_READY | table cleared, user writes accepted
module cii_table_ram #(
    parameter int COLS = cii_pkg::COLS,
    parameter int ROWS = cii_pkg::ROWS,
    parameter int DW   = cii_pkg::DW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [6:0]    char_x_rd,
    input  logic [4:0]    char_y_rd,
    input  logic [6:0]    char_x_we,
    input  logic [4:0]    char_y_we,
    input  logic          rd,
    input  logic          we_vld,
    output logic          we_rdy,
    input  logic [DW-1:0] ascii_we,
    output logic [DW-1:0] ascii_rd
);

    import cii_pkg::*;

    localparam int CELLS = COLS * ROWS;

    clr_state_t    state;
    clr_state_t    state_next;
    logic [AW-1:0] clr_ptr;
    logic [AW-1:0] clr_ptr_next;
    logic          clr_we;

    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic          rd_in_range;
    logic          wr_in_range;

    logic          mem_we;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_rd_en;
    logic          mem_rd_clr;

    assign rd_addr     = cell_addr(char_x_rd, char_y_rd, COLS);
    assign wr_addr     = cell_addr(char_x_we, char_y_we, COLS);
    assign rd_in_range = (int'(char_x_rd) < COLS) && (int'(char_y_rd) < ROWS);
    assign wr_in_range = (int'(char_x_we) < COLS) && (int'(char_y_we) < ROWS);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        clr_we       = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (clr_ptr == AW'(CELLS - 1)) begin
                    state_next   = ST_READY;
                    clr_ptr_next = '0;
                end else begin
                    clr_ptr_next = clr_ptr + AW'(1);
                end
            end
            ST_READY: begin
                state_next = ST_READY;
            end
            default: begin
                state_next   = ST_CLEAR;
                clr_ptr_next = '0;
            end
        endcase
    end

    assign we_rdy = (state == ST_READY);

    // Nothing is written on a reset edge, so the array only changes through
    // the clear sequence or accepted user writes.
    assign mem_we      = rstn && (clr_we || (we_vld && we_rdy && wr_in_range));
    assign mem_wr_addr = clr_we ? clr_ptr : wr_addr;
    assign mem_wr_data = clr_we ? '0 : ascii_we;

    // Out-of-range reads use the RAM output-register clear rather than a
    // mux after the RAM, keeping the read path a plain block-RAM read.
    assign mem_rd_en  = rd && rd_in_range;
    assign mem_rd_clr = !rstn || (rd && !rd_in_range);

    cii_dpram #(
        .DW    (DW),
        .DEPTH (CELLS),
        .AW    (AW)
    ) u_dpram (
        .clk     (clk),
        .we      (mem_we),
        .wr_addr (mem_wr_addr),
        .wr_data (mem_wr_data),
        .rd_en   (mem_rd_en),
        .rd_clr  (mem_rd_clr),
        .rd_addr (rd_addr),
        .rd_data (ascii_rd)
    );

endmodule

// File: tb/tb_cii_table_ram.sv
module tb_cii_table_ram;

    localparam int NC = 70;
    localparam int NR = 30;
    localparam int NCELL = NC * NR;

    logic       clk;
    logic       rstn;
    logic [6:0] char_x_rd;
    logic [4:0] char_y_rd;
    logic [6:0] char_x_we;
    logic [4:0] char_y_we;
    logic       rd;
    logic       we_vld;
    logic       we_rdy;
    logic [7:0] ascii_we;
    logic [7:0] ascii_rd;

    cii_table_ram dut (
        .clk       (clk),
        .rstn      (rstn),
        .char_x_rd (char_x_rd),
        .char_y_rd (char_y_rd),
        .char_x_we (char_x_we),
        .char_y_we (char_y_we),
        .rd        (rd),
        .we_vld    (we_vld),
        .we_rdy    (we_rdy),
        .ascii_we  (ascii_we),
        .ascii_rd  (ascii_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   step_no;
        bit   chk_rd;
        logic [7:0] rd_exp;
        logic rdy_exp;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   started = 0;

    // Reference model: cell contents (-1 = unknown), count of edges with
    // rstn high since the last reset, and the value ascii_rd should show.
    int mem_m[NCELL];
    int run_edges;
    int last_rd;
    int step_cnt;

    // One clock cycle: drive inputs, predict what follows the coming edge.
    task automatic step(input logic r, input logic rd_i, input int xr, input int yr,
                        input logic we_i, input int xw, input int yw, input logic [7:0] d);
        exp_t e;
        rstn      = r;
        rd        = rd_i;
        char_x_rd = 7'(xr);
        char_y_rd = 5'(yr);
        we_vld    = we_i;
        char_x_we = 7'(xw);
        char_y_we = 5'(yw);
        ascii_we  = d;
        if (!r) begin
            run_edges = 0;
            last_rd   = 0;
        end else begin
            bit ready_now;
            ready_now = (run_edges >= NCELL);
            if (rd_i) begin
                if (xr < NC && yr < NR) last_rd = mem_m[yr * NC + xr];
                else                    last_rd = 0;
            end
            if (!ready_now) mem_m[run_edges] = 0;
            else if (we_i && xw < NC && yw < NR) mem_m[yw * NC + xw] = int'(d);
            if (run_edges < NCELL) run_edges++;
        end
        e.step_no = step_cnt;
        e.chk_rd  = (last_rd >= 0);
        e.rd_exp  = 8'(last_rd);
        e.rdy_exp = r && (run_edges >= NCELL);
        q.push_back(e);
        step_cnt++;
        started = 1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic rd_at(input int x, input int y);
        step(1, 1, x, y, 0, 0, 0, 8'h00);
    endtask

    task automatic wr_at(input int x, input int y, input logic [7:0] d);
        step(1, 0, 0, 0, 1, x, y, d);
    endtask

    task automatic rand_step(input logic allow_oob);
        int xr, yr, xw, yw;
        xr = allow_oob ? int'($urandom_range(0, 75)) : int'($urandom_range(0, NC - 1));
        yr = allow_oob ? int'($urandom_range(0, 31)) : int'($urandom_range(0, NR - 1));
        xw = allow_oob ? int'($urandom_range(0, 75)) : int'($urandom_range(0, NC - 1));
        yw = allow_oob ? int'($urandom_range(0, 31)) : int'($urandom_range(0, NR - 1));
        step(1, logic'($urandom_range(0, 1)), xr, yr,
             logic'($urandom_range(0, 2) == 0), xw, yw, 8'($urandom));
    endtask

    // Monitor: every cycle the DUT presents a new output state after the edge.
    initial begin
        exp_t e;
        wait (started);
        forever begin
            @(posedge clk);
            #1;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL queue_empty: no expectation for output at t=%0t", $time);
            end else begin
                e = q.pop_front();
                if (we_rdy !== e.rdy_exp) begin
                    errors++;
                    $display("FAIL we_rdy step=%0d got=%b exp=%b", e.step_no, we_rdy, e.rdy_exp);
                end
                if (e.chk_rd) begin
                    checks++;
                    if (ascii_rd !== e.rd_exp) begin
                        errors++;
                        $display("FAIL ascii_rd step=%0d got=%h exp=%h", e.step_no, ascii_rd, e.rd_exp);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NCELL; i++) mem_m[i] = -1;
        run_edges = 0;
        last_rd   = 0;
        step_cnt  = 0;
        rstn = 0; rd = 0; we_vld = 0;
        char_x_rd = '0; char_y_rd = '0; char_x_we = '0; char_y_we = '0; ascii_we = '0;
        @(negedge clk);

        // Reset, with reads requested (output must still be 00).
        for (int i = 0; i < 3; i++) step(0, 1, i, i, 1, i, i, 8'hEE);

        // Initial clear with random reads and refused writes.
        for (int i = 0; i < NCELL + 10; i++) rand_step(1);

        // Every cell reads 00.
        for (int y = 0; y < NR; y++)
            for (int x = 0; x < NC; x++) rd_at(x, y);

        // Corner writes and reads.
        wr_at(0, 0, 8'h41);
        wr_at(69, 29, 8'h5A);
        rd_at(0, 0);
        rd_at(69, 29);
        idle(1);

        // Out-of-range writes dropped; x=70 must not alias to (0,1).
        wr_at(70, 0, 8'h33);
        wr_at(5, 30, 8'h33);
        rd_at(70, 0);
        rd_at(0, 1);
        rd_at(5, 29);
        rd_at(127, 31);

        // Read-first collision.
        step(1, 1, 10, 3, 1, 10, 3, 8'h61);
        rd_at(10, 3);

        // Hold while rd is low and the address moves.
        rd_at(0, 0);
        step(1, 0, 69, 29, 0, 0, 0, 8'h00);
        step(1, 0, 10, 3, 0, 0, 0, 8'h00);
        step(1, 0, 100, 31, 0, 0, 0, 8'h00);

        // Random traffic, including out-of-range coordinates.
        for (int i = 0; i < 500; i++) rand_step(1);

        // Re-write a known cell near the end of the table, then reset mid-clear.
        wr_at(69, 29, 8'h5A);
        step(0, 0, 0, 0, 0, 0, 0, 8'h00);
        rd_at(69, 29);
        for (int i = 1; i < 1000; i++) rand_step(0);
        step(0, 1, 69, 29, 1, 3, 3, 8'h77);
        rd_at(69, 29);
        for (int i = 1; i < 1500; i++) rand_step(0);
        step(1, 1, 20, 20, 1, 20, 20, 8'h99);
        for (int i = 0; i < 650; i++) step(1, 0, 0, 0, 1, 20, 20, 8'h99);
        rd_at(20, 20);
        rd_at(69, 29);
        for (int i = 0; i < 200; i++) rand_step(1);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
